execute_muldiv: RTL



---
 rtl/execute_muldiv.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/execute_muldiv.sv
// execute_muldiv: iterative multiply/divide unit owning the HI/LO registers.
// Multiplies are shift-add and divides are restoring, one bit per cycle, WIDTH
// cycles per operation. Stall_MD holds dependent requests while iterating.
// Build option: define MULDIV_SIGNED_EN to make MULT/DIV signed (absolute
// values at accept, sign fix-up at completion). Without it, MULT/DIV run as
// MULTU/DIVU.
module execute_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             AnyStall,
  input  logic             Req_ID,
  input  logic [2:0]       Op_ID,
  input  logic [WIDTH-1:0] SrcA_ID,
  input  logic [WIDTH-1:0] SrcB_ID,
  output logic [WIDTH-1:0] Result_MD,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             Stall_MD
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] araw_q, araw_d;   // dividend as issued, for divide by zero
  logic [W2-1:0]    acc_q, acc_d;     // {HI part, LO part} working register
  logic             is_div_q, is_div_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
`ifdef MULDIV_SIGNED_EN
  logic             neg_lo_q, neg_lo_d; // negate product / quotient
  logic             neg_hi_q, neg_hi_d; // negate remainder
`endif

  logic             acc_en;
  logic             signed_op;
  logic             sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [W2-1:0]    step;
  logic [W2-1:0]    res;

  assign Busy      = (state_q == RUN);
  assign Done      = done_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;
  assign Stall_MD  = Req_ID & Busy;
  assign Result_MD = Op_ID[0] ? lo_q : hi_q;

  // Operand conditioning, one iteration step, sign fix-up and next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    araw_d   = araw_q;
    acc_d    = acc_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
`ifdef MULDIV_SIGNED_EN
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    signed_op = Op_ID[0];
`else
    signed_op = 1'b0;
`endif

    acc_en = Req_ID & ~Busy & ~flush & ~AnyStall;
    sa     = signed_op & SrcA_ID[WIDTH-1];
    sb     = signed_op & SrcB_ID[WIDTH-1];
    abs_a  = sa ? -SrcA_ID : SrcA_ID;
    abs_b  = sb ? -SrcB_ID : SrcB_ID;

    // Multiply: add multiplicand into upper half when the low bit is set, shift right.
    mul_sum = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    // Divide: shift next dividend bit into the remainder, subtract if it fits.
    div_shift = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (is_div_q) begin
      if (div_diff[WIDTH]) step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else                 step = {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
    end else begin
      step = {mul_sum, acc_q[WIDTH-1:1]};
    end

    res = step;
`ifdef MULDIV_SIGNED_EN
    if (is_div_q) begin
      if (neg_lo_q) res[WIDTH-1:0]  = -step[WIDTH-1:0];
      if (neg_hi_q) res[W2-1:WIDTH] = -step[W2-1:WIDTH];
    end else if (neg_lo_q) begin
      res = -step;
    end
`endif

    case (state_q)
      IDLE: begin
        if (acc_en) begin
          if (!Op_ID[2]) begin
            state_d  = RUN;
            cnt_d    = CNT_W'(WIDTH);
            is_div_d = Op_ID[1];
            opnd_d   = Op_ID[1] ? abs_b : abs_a;
            acc_d    = {{WIDTH{1'b0}}, (Op_ID[1] ? abs_a : abs_b)};
            dz_d     = Op_ID[1] & (SrcB_ID == '0);
            araw_d   = SrcA_ID;
`ifdef MULDIV_SIGNED_EN
            neg_lo_d = sa ^ sb;
            neg_hi_d = sa;
`endif
          end else if (Op_ID[1:0] == 2'b00) begin
            hi_d = SrcA_ID;
          end else if (Op_ID[1:0] == 2'b01) begin
            lo_d = SrcA_ID;
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (dz_q) begin
              hi_d = araw_q;
              lo_d = '1;
            end else begin
              hi_d = res[W2-1:WIDTH];
              lo_d = res[WIDTH-1:0];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, HI/LO and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      araw_q   <= '0;
      acc_q    <= '0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      araw_q   <= araw_d;
      acc_q    <= acc_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

`ifdef MULDIV_SIGNED_EN
  // Result sign flags captured at accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
    end
  end
`endif

endmodule
